// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle between a FIFO owner (master) and the FIFO itself (slave).
// Widths follow the DATA_W/DEPTH of the FIFO it is bound to.
interface fifo_sync_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] wdata;
    logic              i_wreq;
    logic              i_rreq;
    logic              i_clr_err;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              fifo_isfull;
    logic              fifo_isempty;
    logic              fifo_almost_full;
    logic              fifo_almost_empty;
    logic [CW-1:0]     fifo_count;
    logic              o_overflow;
    logic              o_underflow;

    modport master (
        output wdata, i_wreq, i_rreq, i_clr_err,
        input  rdata, rdata_valid, fifo_isfull, fifo_isempty,
               fifo_almost_full, fifo_almost_empty, fifo_count,
               o_overflow, o_underflow
    );

    modport slave (
        input  wdata, i_wreq, i_rreq, i_clr_err,
        output rdata, rdata_valid, fifo_isfull, fifo_isempty,
               fifo_almost_full, fifo_almost_empty, fifo_count,
               o_overflow, o_underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy, almost-full/empty thresholds and sticky errors.
// Latency: 1 cycle registered read (FWFT=0) or head word shown combinationally (FWFT=1).
// Backpressure: writes rejected when full unless a read is accepted the same cycle; reads rejected when empty.
module fifo_sync_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic             clk,
    input  logic             reset,
    fifo_sync_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              ovf_q;
    logic              unf_q;
    logic              is_full;
    logic              is_empty;
    logic              rd_acc;
    logic              wr_acc;

    assign is_empty = (count == '0);
    assign is_full  = (count == FULL_CNT);
    assign rd_acc   = bus.i_rreq & ~is_empty;
    // A full FIFO can still take a write when a slot is freed in the same cycle.
    assign wr_acc   = bus.i_wreq & (~is_full | rd_acc);

    assign bus.fifo_isempty      = is_empty;
    assign bus.fifo_isfull       = is_full;
    assign bus.fifo_almost_full  = (count >= AF_CNT);
    assign bus.fifo_almost_empty = (count <= AE_CNT);
    assign bus.fifo_count        = count;
    assign bus.o_overflow        = ovf_q;
    assign bus.o_underflow       = unf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc && !reset) mem[wr_ptr] <= bus.wdata;
    end

    // Set wins over clear so an error in the clearing cycle is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.i_wreq && !wr_acc) ovf_q <= 1'b1;
            else if (bus.i_clr_err)    ovf_q <= 1'b0;
            if (bus.i_rreq && !rd_acc) unf_q <= 1'b1;
            else if (bus.i_clr_err)    unf_q <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.rdata       = is_empty ? '0 : mem[rd_ptr];
            assign bus.rdata_valid = ~is_empty;
        end else begin : g_reg
            logic [DATA_W-1:0] rdata_q;
            logic              rvld_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_q <= '0;
                    rvld_q  <= 1'b0;
                end else begin
                    rvld_q <= rd_acc;
                    if (rd_acc) rdata_q <= mem[rd_ptr];
                end
            end

            assign bus.rdata       = rdata_q;
            assign bus.rdata_valid = rvld_q;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_sync_param.sv
// Drives a registered-read and an FWFT instance with identical traffic and checks both against a queue model.
module tb_fifo_sync_param;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          wreq = 1'b0;
    logic          rreq = 1'b0;
    logic          clr = 1'b0;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [DW-1:0] q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_rvld = 1'b0;

    always #5 clk = ~clk;

    fifo_sync_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) if_r ();
    fifo_sync_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) if_f ();

    assign if_r.wdata = wdata;  assign if_f.wdata = wdata;
    assign if_r.i_wreq = wreq;  assign if_f.i_wreq = wreq;
    assign if_r.i_rreq = rreq;  assign if_f.i_rreq = rreq;
    assign if_r.i_clr_err = clr; assign if_f.i_clr_err = clr;

    fifo_sync_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0))
        u_reg (.clk(clk), .reset(reset), .bus(if_r));
    fifo_sync_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1))
        u_fwft (.clk(clk), .reset(reset), .bus(if_f));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=0x%0h expected=0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count",     32'(if_r.fifo_count),        32'(n));
        chk("isempty",   32'(if_r.fifo_isempty),      32'(n == 0));
        chk("isfull",    32'(if_r.fifo_isfull),       32'(n == DEPTH));
        chk("almost_f",  32'(if_r.fifo_almost_full),  32'(n >= AF));
        chk("almost_e",  32'(if_r.fifo_almost_empty), 32'(n <= AE));
        chk("overflow",  32'(if_r.o_overflow),        32'(m_ovf));
        chk("underflow", 32'(if_r.o_underflow),       32'(m_unf));
        chk("reg_vld",   32'(if_r.rdata_valid),       32'(m_rvld));
        chk("reg_rdata", 32'(if_r.rdata),             32'(m_rdata));
        chk("fw_count",  32'(if_f.fifo_count),        32'(n));
        chk("fw_ovf",    32'(if_f.o_overflow),        32'(m_ovf));
        chk("fw_unf",    32'(if_f.o_underflow),       32'(m_unf));
        chk("fw_vld",    32'(if_f.rdata_valid),       32'(n != 0));
        if (n != 0) chk("fw_rdata", 32'(if_f.rdata), 32'(q[0]));
    endtask

    // One clock of traffic: drive at negedge, update model, sample 1 ns after posedge.
    task automatic step(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
        logic rd_ok, wr_ok;
        @(negedge clk);
        wreq = w; rreq = r; clr = c; wdata = d;
        rd_ok = r && (q.size() > 0);
        wr_ok = w && ((q.size() < DEPTH) || rd_ok);
        if (rd_ok) begin
            m_rdata = q.pop_front();
            m_rvld  = 1'b1;
        end else begin
            m_rvld  = 1'b0;
        end
        if (wr_ok) q.push_back(d);
        if (w && !wr_ok) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (r && !rd_ok) m_unf = 1'b1; else if (c) m_unf = 1'b0;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1; wreq = 1'b1; rreq = 1'b1; clr = 1'b0;
        wdata = DW'($urandom);
        repeat (cycles) @(posedge clk);
        #1;
        q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_rdata = '0; m_rvld = 1'b0;
        check_all();
        @(negedge clk);
        reset = 1'b0; wreq = 1'b0; rreq = 1'b0;
    endtask

    initial begin
        int wp, rp;
        // reset with write request held high
        do_reset(2);
        step(0, 0, 0, 8'h00);

        // fill, then one rejected write
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, DW'(i));
        step(1, 0, 0, 8'hEE);
        step(0, 0, 1, 8'h00);

        // full with simultaneous read and write
        step(1, 1, 0, 8'hAA);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'h00);

        // empty read, then empty read+write
        step(0, 1, 0, 8'h00);
        step(1, 1, 0, 8'h55);
        step(0, 0, 1, 8'h00);
        step(0, 1, 0, 8'h00);

        // threshold walk up to 15 and back down to 12
        do_reset(1);
        for (int i = 0; i < 15; i++) step(1, 0, 0, DW'($urandom));
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);

        // FWFT visibility without a read
        do_reset(1);
        step(1, 0, 0, 8'h3C);
        step(0, 0, 0, 8'h00);
        step(0, 1, 0, 8'h00);

        // randomized mixed traffic with drifting bias and one mid-stream reset
        for (int ph = 0; ph < 8; ph++) begin
            wp = (ph % 2 == 0) ? 75 : 30;
            rp = (ph % 2 == 0) ? 30 : 75;
            for (int i = 0; i < 3 * DEPTH; i++)
                step($urandom_range(99) < wp, $urandom_range(99) < rp,
                     $urandom_range(99) < 5, DW'($urandom));
            if (ph == 4) do_reset(1);
        end

        while (q.size() > 0) step(0, 1, 0, 8'h00);
        step(0, 1, 1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
